// File: rtl/mem_lsu.sv
// mem_lsu: MIPS memory stage with wait-state load/store unit feeding the MEM/WB register
module mem_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  input  logic        flush_i,
  input  logic        ram_ready_i,
  input  logic [31:0] ram_data_i,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  output logic        stall_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic [31:0] badvaddr_o
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [3:0] op_q;
  logic [1:0] off_q;
  logic [4:0] wd_q;
  logic kill_q;
  logic is_load, is_store, is_mem, is_half, is_word, mis, accept;
  logic [3:0] sel;
  logic [31:0] st_data, load_val;
  logic [7:0] lb;
  logic [15:0] lh;
  always_comb begin
    is_load = memop_i >= 4'd1 && memop_i <= 4'd5;
    is_store = memop_i >= 4'd6 && memop_i <= 4'd8;
    is_mem = is_load || is_store;
    is_half = memop_i == 4'd3 || memop_i == 4'd4 || memop_i == 4'd7;
    is_word = memop_i == 4'd5 || memop_i == 4'd8;
    mis = (is_half && addr_i[0]) || (is_word && addr_i[1:0] != 2'b00);
    accept = is_mem && !mis && !flush_i;
    sel = is_word ? 4'b1111 : is_half ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_i[1:0];
    st_data = memop_i == 4'd6 ? {4{sdata_i[7:0]}} : memop_i == 4'd7 ? {2{sdata_i[15:0]}} : sdata_i;
    stall_o = state == IDLE ? accept : !ram_ready_i;
  end
  // Lane selection uses the offset latched at acceptance, not the live address
  always_comb begin
    lb = ram_data_i[{off_q, 3'b000} +: 8];
    lh = off_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
    load_val = op_q == 4'd1 ? {{24{lb[7]}}, lb} :
               op_q == 4'd2 ? {24'b0, lb} :
               op_q == 4'd3 ? {{16{lh[15]}}, lh} :
               op_q == 4'd4 ? {16'b0, lh} : ram_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      op_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      kill_q <= 1'b0;
      ram_ce_o <= 1'b0;
      ram_we_o <= 1'b0;
      ram_addr_o <= '0;
      ram_sel_o <= '0;
      ram_data_o <= '0;
      wb_wd_o <= '0;
      wb_wreg_o <= 1'b0;
      wb_wdata_o <= '0;
      exc_adel_o <= 1'b0;
      exc_ades_o <= 1'b0;
      badvaddr_o <= '0;
    end else if (state == IDLE) begin
      wb_wd_o <= wd_i;
      wb_wdata_o <= wdata_i;
      wb_wreg_o <= !is_mem && wreg_i && !flush_i;
      exc_adel_o <= is_load && mis && !flush_i;
      exc_ades_o <= is_store && mis && !flush_i;
      if (is_mem && mis && !flush_i) badvaddr_o <= addr_i;
      if (accept) begin
        state <= ACCESS;
        op_q <= memop_i;
        off_q <= addr_i[1:0];
        wd_q <= wd_i;
        kill_q <= 1'b0;
        ram_ce_o <= 1'b1;
        ram_we_o <= is_store;
        ram_addr_o <= {addr_i[31:2], 2'b00};
        ram_sel_o <= sel;
        ram_data_o <= st_data;
      end
    end else begin
      exc_adel_o <= 1'b0;
      exc_ades_o <= 1'b0;
      wb_wreg_o <= 1'b0;
      kill_q <= kill_q || flush_i;
      if (ram_ready_i) begin
        state <= IDLE;
        kill_q <= 1'b0;
        ram_ce_o <= 1'b0;
        ram_we_o <= 1'b0;
        wb_wd_o <= wd_q;
        wb_wdata_o <= load_val;
        wb_wreg_o <= op_q < 4'd6 && !kill_q && !flush_i;
      end
    end
  end
endmodule
